wb_write_queue: RTL and testbench

Writeback-side writer for the 16×32 register file. It accepts completed results from the execute/memory pipeline through a valid/ready handshake and buffers them in an in-order FIFO. It issues at most one write per cycle on the register file's single write port. It also answers decode-stage hazard queries ("is a write to register r still pending?") and, when configured, forwards the youngest pending value.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_fifo_mem.sv | 31 +++
 rtl/wb_write_queue.sv | 162 ++++++++++++++++
 tb/tb_wb_write_queue.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants, entry type and helpers for the writeback write queue
package wb_pkg;

    localparam int NUM_REGS = 16;
    localparam int REG_AW   = 4;
    localparam int REG_DW   = 32;

    localparam logic [REG_AW-1:0] REG_RSVD_LO = 4'hE;
    localparam logic [REG_AW-1:0] REG_RSVD_HI = 4'hF;

    typedef struct packed {
        logic [REG_AW-1:0] dreg;
        logic [REG_DW-1:0] data;
    } wb_entry_t;

    // Registers 14/15 are ignored by the register file, so results for them are dropped.
    function automatic logic is_reserved(input logic [REG_AW-1:0] dreg);
        return (dreg == REG_RSVD_LO) || (dreg == REG_RSVD_HI);
    endfunction

endpackage

// File: rtl/wb_fifo_mem.sv
// rtl/wb_fifo_mem.sv - DEPTH-entry storage with one write port and all entries readable
module wb_fifo_mem
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [PW-1:0]     i_waddr,
    input  wb_entry_t         i_wentry,
    output wb_entry_t         o_entries [DEPTH]
);

    wb_entry_t r_mem [DEPTH];

    // Storage needs no reset: occupancy is tracked by the pointers in the parent.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wentry;
        end
    end

    // Every entry is exposed so the hazard matcher can scan the whole queue.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            o_entries[i] = r_mem[i];
        end
    end

endmodule

// File: rtl/wb_write_queue.sv
// rtl/wb_write_queue.sv - in-order writeback queue with hazard lookup; optional forwarding via WB_FWD_EN
module wb_write_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_dreg,
    input  logic [DW-1:0] in_data,
    input  logic          hold,
    output logic          wr_en,
    output logic [AW-1:0] wr_dreg,
    output logic [DW-1:0] wr_data,
    input  logic [AW-1:0] q1_reg,
    input  logic [AW-1:0] q2_reg,
    output logic          q1_busy,
    output logic          q2_busy,
    output logic [CW-1:0] count,
`ifdef WB_FWD_EN
    output logic          fwd1_hit,
    output logic          fwd2_hit,
    output logic [DW-1:0] fwd1_data,
    output logic [DW-1:0] fwd2_data,
`endif
    output logic [7:0]    drop_count
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [CW-1:0] r_wr_ptr;
    logic [CW-1:0] r_rd_ptr;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_dreg;
    logic [DW-1:0] r_wr_data;
    logic [7:0]    r_drop_cnt;

    logic [CW-1:0] w_count;
    logic          w_empty;
    logic          w_accept;
    logic          w_push;
    logic          w_bypass;
    logic          w_enq;
    logic          w_pop;
    wb_entry_t     w_in_entry;
    wb_entry_t     w_entries [DEPTH];
    wb_entry_t     w_head;

    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_empty  = (w_count == '0);
    assign in_ready = (w_count != FULL_CNT);
    assign w_accept = in_valid && in_ready;
    assign w_push   = w_accept && !is_reserved(in_dreg);
    // An empty queue hands a new result straight to the output stage so it writes next cycle.
    assign w_bypass = w_push && w_empty && !hold;
    assign w_enq    = w_push && !w_bypass;
    assign w_pop    = !hold && !w_empty;

    assign w_in_entry.dreg = in_dreg;
    assign w_in_entry.data = in_data;
    assign w_head          = w_entries[r_rd_ptr[PW-1:0]];

    wb_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk       (clk),
        .i_we      (w_enq),
        .i_waddr   (r_wr_ptr[PW-1:0]),
        .i_wentry  (w_in_entry),
        .o_entries (w_entries)
    );

    // Pointer update; the extra MSB separates full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + CW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + CW'(1);
        end
    end

    // Output stage holds one write for a full cycle; dreg/data keep last value when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_en   <= 1'b0;
            r_wr_dreg <= '0;
            r_wr_data <= '0;
        end else if (w_pop) begin
            r_wr_en   <= 1'b1;
            r_wr_dreg <= w_head.dreg;
            r_wr_data <= w_head.data;
        end else if (w_bypass) begin
            r_wr_en   <= 1'b1;
            r_wr_dreg <= in_dreg;
            r_wr_data <= in_data;
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    // Saturating count of results discarded for reserved destinations.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (w_accept && is_reserved(in_dreg) && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    function automatic logic lookup_busy(input logic [AW-1:0] q);
        logic          hit;
        logic [PW-1:0] idx;
        hit = r_wr_en && (r_wr_dreg == q);
        for (int k = 0; k < DEPTH; k++) begin
            idx = r_rd_ptr[PW-1:0] + PW'(k);
            if ((CW'(k) < w_count) && (w_entries[idx].dreg == q)) hit = 1'b1;
        end
        return hit && !is_reserved(q);
    endfunction

    // Hazard query: any pending write (queued or in the output stage) to the operand register.
    always_comb begin
        q1_busy = lookup_busy(q1_reg);
        q2_busy = lookup_busy(q2_reg);
    end

`ifdef WB_FWD_EN
    // Output stage is oldest, then head to tail; later matches override so the youngest wins.
    function automatic logic [DW-1:0] lookup_data(input logic [AW-1:0] q);
        logic [DW-1:0] d;
        logic [PW-1:0] idx;
        d = '0;
        if (r_wr_en && (r_wr_dreg == q)) d = r_wr_data;
        for (int k = 0; k < DEPTH; k++) begin
            idx = r_rd_ptr[PW-1:0] + PW'(k);
            if ((CW'(k) < w_count) && (w_entries[idx].dreg == q)) d = w_entries[idx].data;
        end
        return is_reserved(q) ? '0 : d;
    endfunction

    // Forwarded value for each decode operand; hit mirrors busy.
    always_comb begin
        fwd1_hit  = q1_busy;
        fwd2_hit  = q2_busy;
        fwd1_data = q1_busy ? lookup_data(q1_reg) : '0;
        fwd2_data = q2_busy ? lookup_data(q2_reg) : '0;
    end
`endif

    assign wr_en      = r_wr_en;
    assign wr_dreg    = r_wr_dreg;
    assign wr_data    = r_wr_data;
    assign count      = w_count;
    assign drop_count = r_drop_cnt;

endmodule

// File: tb/tb_wb_write_queue.sv
// tb/tb_wb_write_queue.sv - directed self-checking bench for wb_write_queue
module tb_wb_write_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_dreg;
    logic [31:0] in_data;
    logic        hold;
    logic        wr_en;
    logic [3:0]  wr_dreg;
    logic [31:0] wr_data;
    logic [3:0]  q1_reg, q2_reg;
    logic        q1_busy, q2_busy;
    logic [2:0]  count;
    logic [7:0]  drop_count;
`ifdef WB_FWD_EN
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_data, fwd2_data;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_write_queue dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_dreg    (in_dreg),
        .in_data    (in_data),
        .hold       (hold),
        .wr_en      (wr_en),
        .wr_dreg    (wr_dreg),
        .wr_data    (wr_data),
        .q1_reg     (q1_reg),
        .q2_reg     (q2_reg),
        .q1_busy    (q1_busy),
        .q2_busy    (q2_busy),
        .count      (count),
`ifdef WB_FWD_EN
        .fwd1_hit   (fwd1_hit),
        .fwd2_hit   (fwd2_hit),
        .fwd1_data  (fwd1_data),
        .fwd2_data  (fwd2_data),
`endif
        .drop_count (drop_count)
    );

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_dreg = '0; in_data = '0; hold = 1'b0;
        q1_reg = 4'd0; q2_reg = 4'd0;
        tick(); tick();

        // Reset values
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_dreg", wr_dreg, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_drop", drop_count, 0);
        chk("rst_busy1", q1_busy, 0);
        chk("rst_busy2", q2_busy, 0);
`ifdef WB_FWD_EN
        chk("rst_fwd1_hit", fwd1_hit, 0);
        chk("rst_fwd1_data", fwd1_data, 0);
`endif
        reset = 1'b0;
        tick();

        // Basic write: one cycle latency, one cycle pulse
        in_valid = 1'b1; in_dreg = 4'd3; in_data = 32'hDEADBEEF;
        tick();
        in_valid = 1'b0;
        chk("basic_wr_en", wr_en, 1);
        chk("basic_wr_dreg", wr_dreg, 3);
        chk("basic_wr_data", wr_data, 32'hDEADBEEF);
        tick();
        chk("basic_wr_en_off", wr_en, 0);
        chk("basic_dreg_keep", wr_dreg, 3);

        // Full and backpressure
        hold = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1; in_dreg = 4'(k); in_data = 32'h100 + 32'(k);
            tick();
        end
        in_dreg = 4'd5; in_data = 32'h105;
        chk("full_in_ready", in_ready, 0);
        chk("full_count", count, 4);
        chk("full_no_wr", wr_en, 0);
        tick();
        chk("stall_count", count, 4);
        chk("stall_no_wr", wr_en, 0);
        hold = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 2) in_valid = 1'b0;
            chk($sformatf("drain%0d_en", k), wr_en, 1);
            chk($sformatf("drain%0d_dreg", k), wr_dreg, 40'(k));
            chk($sformatf("drain%0d_data", k), wr_data, 40'(32'h100 + 32'(k)));
        end
        tick();
        chk("drain_done_en", wr_en, 0);
        chk("drain_done_cnt", count, 0);

        // Reserved drop
        in_valid = 1'b1; in_dreg = 4'd14; in_data = 32'h1;
        tick();
        chk("rsvd14_no_wr", wr_en, 0);
        in_dreg = 4'd15;
        tick();
        in_valid = 1'b0;
        chk("rsvd15_no_wr", wr_en, 0);
        chk("rsvd_drop2", drop_count, 2);
        chk("rsvd_count", count, 0);
        in_valid = 1'b1;
        for (int k = 0; k < 298; k++) begin
            in_dreg = (k % 2 == 0) ? 4'd14 : 4'd15;
            tick();
        end
        in_valid = 1'b0;
        chk("rsvd_sat", drop_count, 255);
        chk("rsvd_sat_no_wr", wr_en, 0);

        // Busy and forward ordering
        hold = 1'b1;
        in_valid = 1'b1; in_dreg = 4'd7; in_data = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        in_valid = 1'b0;
        q1_reg = 4'd7; q2_reg = 4'd14;
        #1;
        chk("busy_r7", q1_busy, 1);
        chk("busy_r14", q2_busy, 0);
`ifdef WB_FWD_EN
        chk("fwd_r7_hit", fwd1_hit, 1);
        chk("fwd_r7_young", fwd1_data, 32'h22);
        chk("fwd_r14_hit", fwd2_hit, 0);
`endif
        q2_reg = 4'd8;
        #1;
        chk("busy_r8", q2_busy, 0);
        hold = 1'b0;
        tick();
        chk("busy_pop1_wr", wr_data, 32'h11);
        chk("busy_pop1", q1_busy, 1);
`ifdef WB_FWD_EN
        chk("fwd_pop1_young", fwd1_data, 32'h22);
`endif
        tick();
        chk("busy_pop2_wr", wr_data, 32'h22);
        chk("busy_pop2", q1_busy, 1);
`ifdef WB_FWD_EN
        chk("fwd_pop2_out", fwd1_data, 32'h22);
`endif
        tick();
        chk("busy_gone", q1_busy, 0);
        chk("busy_gone_en", wr_en, 0);

        // Streaming push/pop
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; in_dreg = 4'(k + 1); in_data = 32'hA00 + 32'(k);
            tick();
            chk($sformatf("stream%0d_cnt", k), 40'(count <= 3'd1), 1);
            chk($sformatf("stream%0d_en", k), wr_en, 1);
            chk($sformatf("stream%0d_dreg", k), wr_dreg, 40'(k + 1));
            chk($sformatf("stream%0d_data", k), wr_data, 40'(32'hA00 + 32'(k)));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_end_en", wr_en, 0);
        chk("stream_end_cnt", count, 0);

        // Mid-operation reset
        hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_dreg = 4'(k + 2); in_data = 32'hB00 + 32'(k);
            tick();
        end
        in_valid = 1'b0; hold = 1'b0;
        tick();
        chk("pre_rst_en", wr_en, 1);
        chk("pre_rst_cnt", count, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_en", wr_en, 0);
        chk("mid_rst_cnt", count, 0);
        chk("mid_rst_ready", in_ready, 1);
        q1_reg = 4'd3;
        #1;
        chk("mid_rst_busy", q1_busy, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("post_rst%0d_en", k), wr_en, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
